// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the FIFO read port, the adapter and the
// downstream valid/ready consumer. The adapter uses the master view and the
// surrounding environment (FIFO owner plus stream sink) uses the slave view.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  Empty;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  Read_EN;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  pkt_count;

  modport master (
    input  enable, Empty, DataOut, m_ready,
    output Read_EN, m_data, m_valid, m_last, pkt_count
  );

  modport slave (
    output enable, Empty, DataOut, m_ready,
    input  Read_EN, m_data, m_valid, m_last, pkt_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO. Pops words through
// Read_EN/DataOut/Empty and re-presents them as a valid/ready stream with a
// last flag every PKT_LEN words. A two-entry buffer hides the FIFO's
// one-cycle read latency so a word can leave every clock; a read is only
// issued when the word it returns is guaranteed a free buffer slot.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               rst,
  fifo_rd_stream_if.master  bus
);
  localparam int IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  pktCount_q, pktCount_d;

  logic       mValid;
  logic       mLast;
  logic       pop;
  logic       readEn;
  logic [1:0] occAfterPop;
  logic [2:0] occSum;

  // Handshake, read credit and next-state for buffer, word index and packet counter
  always_comb begin
    mValid      = (occ_q != 2'd0);
    mLast       = mValid && (idx_q == LAST_IDX);
    pop         = mValid && bus.m_ready;
    occAfterPop = occ_q - {1'b0, pop};
    occSum      = {1'b0, occAfterPop} + {2'b00, pend_q};
    readEn      = !rst && bus.enable && !bus.Empty && (occSum < 3'd2);

    occ_d      = occSum[1:0];
    pend_d     = readEn;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    idx_d      = idx_q;
    pktCount_d = pktCount_q;

    if (pop) begin
      buf0_d = buf1_q;
      idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      if (mLast) begin
        pktCount_d = pktCount_q + CNT_WIDTH'(1);
      end
    end

    // The returning word lands at the tail seen after this cycle's pop, so
    // with one entry being popped it becomes the new head on the same edge.
    if (pend_q) begin
      if (occAfterPop == 2'd0) begin
        buf0_d = bus.DataOut;
      end else begin
        buf1_d = bus.DataOut;
      end
    end
  end

  // State registers; reset also discards any read still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      pktCount_q <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      pktCount_q <= pktCount_d;
    end
  end

  // The credit check must keep the buffer from ever holding a third word
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occSum <= 3'd2) else $error("fifo_rd_stream: output buffer overflow");
    end
  end

  assign bus.Read_EN   = readEn;
  assign bus.m_valid   = mValid;
  assign bus.m_last    = mLast;
  assign bus.m_data    = buf0_q;
  assign bus.pkt_count = pktCount_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream. A queue models the FIFO: a Read_EN seen
// in a cycle pops the queue onto DataOut just after the closing edge.
// Outputs are sampled on the falling edge, inputs change 1ns after rising.
module tb_fifo_rd_stream;
  localparam int DW = 16;
  localparam int PL = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running 10ns clock
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] fifoQ[$];
  int            cycleCnt = 0;
  logic          sRead, sValid, sLast;
  logic [DW-1:0] sData;
  logic [CW-1:0] sCount;

  logic [DW-1:0] beatData[$];
  logic          beatLast[$];
  int            beatCycle[$];
  int            readCycle[$];
  int            readCount, emptyReadCount, maxOcc;

  task automatic clearLog();
    beatData.delete();
    beatLast.delete();
    beatCycle.delete();
    readCycle.delete();
    readCount      = 0;
    emptyReadCount = 0;
    maxOcc         = 0;
  endtask

  // One clock: sample outputs at the falling edge, then play the FIFO after the rising edge
  task automatic tick();
    @(negedge clk);
    sRead  = bus.Read_EN;
    sValid = bus.m_valid;
    sLast  = bus.m_last;
    sData  = bus.m_data;
    sCount = bus.pkt_count;
    if (sRead) begin
      readCount++;
      readCycle.push_back(cycleCnt);
      if (bus.Empty) emptyReadCount++;
    end
    if (int'(dut.occ_q) > maxOcc) maxOcc = int'(dut.occ_q);
    if (sValid && bus.m_ready) begin
      beatData.push_back(sData);
      beatLast.push_back(sLast);
      beatCycle.push_back(cycleCnt);
    end
    @(posedge clk);
    #1;
    cycleCnt++;
    if (sRead && fifoQ.size() > 0) bus.DataOut = fifoQ.pop_front();
    bus.Empty = (fifoQ.size() == 0);
  endtask

  task automatic loadFifo(input int n, input int base);
    for (int i = 0; i < n; i++) fifoQ.push_back(DW'(base + i));
    bus.Empty = (fifoQ.size() == 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    fifoQ.delete();
    bus.Empty   = 1'b1;
    bus.DataOut = '0;
    bus.enable  = 1'b1;
    bus.m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    loadFifo(1, 7);
    tick();
    assertCount++; if (sRead !== 1'b0) begin failCount++; $display("[TB] FAIL reset_read_en: got %0h expected 0", sRead); end
    assertCount++; if (sValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0h expected 0", sValid); end
    assertCount++; if (sLast !== 1'b0) begin failCount++; $display("[TB] FAIL reset_last: got %0h expected 0", sLast); end
    assertCount++; if (sData !== '0) begin failCount++; $display("[TB] FAIL reset_data: got %0h expected 0", sData); end
    assertCount++; if (sCount !== '0) begin failCount++; $display("[TB] FAIL reset_count: got %0h expected 0", sCount); end
    fifoQ.delete();
    bus.Empty = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_three_words();
    doReset();
    bus.m_ready = 1'b1;
    clearLog();
    loadFifo(3, 1);
    for (int i = 0; i < 10; i++) tick();
    assertCount++; if (readCount !== 3) begin failCount++; $display("[TB] FAIL three_reads: got %0d expected 3", readCount); end
    assertCount++; if (beatData.size() !== 3) begin failCount++; $display("[TB] FAIL three_beats: got %0d expected 3", beatData.size()); end
    if (beatData.size() == 3 && readCycle.size() == 3) begin
      assertCount++; if (readCycle[2] - readCycle[0] !== 2) begin failCount++; $display("[TB] FAIL three_read_span: got %0d expected 2", readCycle[2] - readCycle[0]); end
      assertCount++; if (beatCycle[0] - readCycle[0] !== 2) begin failCount++; $display("[TB] FAIL three_latency: got %0d expected 2", beatCycle[0] - readCycle[0]); end
      for (int i = 0; i < 3; i++) begin
        assertCount++; if (beatData[i] !== DW'(i + 1)) begin failCount++; $display("[TB] FAIL three_data%0d: got %0h expected %0h", i, beatData[i], i + 1); end
        assertCount++; if (beatLast[i] !== 1'b0) begin failCount++; $display("[TB] FAIL three_last%0d: got %0h expected 0", i, beatLast[i]); end
      end
    end
    assertCount++; if (sCount !== CW'(0)) begin failCount++; $display("[TB] FAIL three_count: got %0d expected 0", sCount); end
  endtask

  task automatic test_burst32();
    int orderErr = 0;
    int lastErr  = 0;
    doReset();
    bus.m_ready = 1'b1;
    clearLog();
    loadFifo(32, 1);
    for (int i = 0; i < 45; i++) tick();
    assertCount++; if (beatData.size() !== 32) begin failCount++; $display("[TB] FAIL burst_beats: got %0d expected 32", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] !== DW'(i + 1)) orderErr++;
      if (beatLast[i] !== (((i + 1) % PL) == 0)) lastErr++;
    end
    assertCount++; if (orderErr !== 0) begin failCount++; $display("[TB] FAIL burst_order: got %0d errors expected 0", orderErr); end
    assertCount++; if (lastErr !== 0) begin failCount++; $display("[TB] FAIL burst_last: got %0d errors expected 0", lastErr); end
    if (beatCycle.size() == 32) begin
      assertCount++; if (beatCycle[31] - beatCycle[0] !== 31) begin failCount++; $display("[TB] FAIL burst_bubbles: got span %0d expected 31", beatCycle[31] - beatCycle[0]); end
    end
    assertCount++; if (sCount !== CW'(4)) begin failCount++; $display("[TB] FAIL burst_count: got %0d expected 4", sCount); end
    assertCount++; if (readCount !== 32) begin failCount++; $display("[TB] FAIL burst_reads: got %0d expected 32", readCount); end
    assertCount++; if (emptyReadCount !== 0) begin failCount++; $display("[TB] FAIL burst_empty_read: got %0d expected 0", emptyReadCount); end
  endtask

  task automatic test_backpressure();
    int orderErr = 0;
    doReset();
    bus.m_ready = 1'b0;
    clearLog();
    loadFifo(10, 1);
    for (int i = 0; i < 20; i++) tick();
    assertCount++; if (readCount !== 2) begin failCount++; $display("[TB] FAIL stall_reads: got %0d expected 2", readCount); end
    assertCount++; if (dut.occ_q !== 2'd2) begin failCount++; $display("[TB] FAIL stall_occ: got %0d expected 2", dut.occ_q); end
    assertCount++; if (sValid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_valid: got %0h expected 1", sValid); end
    assertCount++; if (sData !== DW'(1)) begin failCount++; $display("[TB] FAIL stall_data: got %0h expected 1", sData); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    assertCount++; if (beatData.size() !== 10) begin failCount++; $display("[TB] FAIL stall_beats: got %0d expected 10", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) if (beatData[i] !== DW'(i + 1)) orderErr++;
    assertCount++; if (orderErr !== 0) begin failCount++; $display("[TB] FAIL stall_order: got %0d errors expected 0", orderErr); end
  endtask

  task automatic test_toggle();
    int orderErr = 0;
    int lastErr  = 0;
    doReset();
    bus.m_ready = 1'b0;
    clearLog();
    loadFifo(16, 1);
    for (int i = 0; i < 60; i++) begin
      bus.m_ready = ~bus.m_ready;
      tick();
    end
    assertCount++; if (beatData.size() !== 16) begin failCount++; $display("[TB] FAIL toggle_beats: got %0d expected 16", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] !== DW'(i + 1)) orderErr++;
      if (beatLast[i] !== (i == 7 || i == 15)) lastErr++;
    end
    assertCount++; if (orderErr !== 0) begin failCount++; $display("[TB] FAIL toggle_order: got %0d errors expected 0", orderErr); end
    assertCount++; if (lastErr !== 0) begin failCount++; $display("[TB] FAIL toggle_last: got %0d errors expected 0", lastErr); end
    assertCount++; if (maxOcc > 2) begin failCount++; $display("[TB] FAIL toggle_max_occ: got %0d expected at most 2", maxOcc); end
    assertCount++; if (emptyReadCount !== 0) begin failCount++; $display("[TB] FAIL toggle_empty_read: got %0d expected 0", emptyReadCount); end
    assertCount++; if (sCount !== CW'(2)) begin failCount++; $display("[TB] FAIL toggle_count: got %0d expected 2", sCount); end
  endtask

  task automatic test_enable();
    int guard = 0;
    int readsBefore;
    int orderErr = 0;
    int lastErr  = 0;
    doReset();
    bus.m_ready = 1'b1;
    clearLog();
    loadFifo(16, 1);
    while (beatData.size() < 5 && guard < 30) begin
      tick();
      guard++;
    end
    assertCount++; if (beatData.size() !== 5) begin failCount++; $display("[TB] FAIL enable_reach5: got %0d expected 5", beatData.size()); end
    bus.enable  = 1'b0;
    readsBefore = readCount;
    for (int i = 0; i < 10; i++) tick();
    assertCount++; if (beatData.size() - 5 !== 2) begin failCount++; $display("[TB] FAIL enable_drain: got %0d expected 2", beatData.size() - 5); end
    assertCount++; if (readCount - readsBefore !== 0) begin failCount++; $display("[TB] FAIL enable_hold_reads: got %0d expected 0", readCount - readsBefore); end
    assertCount++; if (sValid !== 1'b0) begin failCount++; $display("[TB] FAIL enable_idle_valid: got %0h expected 0", sValid); end
    bus.enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    assertCount++; if (beatData.size() !== 16) begin failCount++; $display("[TB] FAIL enable_beats: got %0d expected 16", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] !== DW'(i + 1)) orderErr++;
      if (beatLast[i] !== (i == 7 || i == 15)) lastErr++;
    end
    assertCount++; if (orderErr !== 0) begin failCount++; $display("[TB] FAIL enable_order: got %0d errors expected 0", orderErr); end
    assertCount++; if (lastErr !== 0) begin failCount++; $display("[TB] FAIL enable_last: got %0d errors expected 0", lastErr); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int orderErr = 0;
    int lastErr  = 0;
    doReset();
    bus.m_ready = 1'b1;
    clearLog();
    loadFifo(11, 1);
    while (beatData.size() < 9 && guard < 40) begin
      tick();
      guard++;
    end
    bus.m_ready = 1'b0;
    assertCount++; if (dut.occ_q !== 2'd1) begin failCount++; $display("[TB] FAIL mid_occ: got %0d expected 1", dut.occ_q); end
    assertCount++; if (dut.pend_q !== 1'b1) begin failCount++; $display("[TB] FAIL mid_pend: got %0h expected 1", dut.pend_q); end
    assertCount++; if (bus.pkt_count !== CW'(1)) begin failCount++; $display("[TB] FAIL mid_count_pre: got %0d expected 1", bus.pkt_count); end
    rst = 1'b1;
    tick();
    assertCount++; if (sValid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_valid: got %0h expected 0", sValid); end
    assertCount++; if (sCount !== CW'(0)) begin failCount++; $display("[TB] FAIL mid_count: got %0d expected 0", sCount); end
    assertCount++; if (sRead !== 1'b0) begin failCount++; $display("[TB] FAIL mid_read_en: got %0h expected 0", sRead); end
    fifoQ.delete();
    bus.Empty = 1'b1;
    rst = 1'b0;
    assertCount++; if (dut.idx_q !== '0) begin failCount++; $display("[TB] FAIL mid_idx: got %0d expected 0", dut.idx_q); end
    clearLog();
    bus.m_ready = 1'b1;
    loadFifo(8, 'h100);
    for (int i = 0; i < 15; i++) tick();
    assertCount++; if (beatData.size() !== 8) begin failCount++; $display("[TB] FAIL mid_beats: got %0d expected 8", beatData.size()); end
    for (int i = 0; i < beatData.size(); i++) begin
      if (beatData[i] !== DW'('h100 + i)) orderErr++;
      if (beatLast[i] !== (i == 7)) lastErr++;
    end
    assertCount++; if (orderErr !== 0) begin failCount++; $display("[TB] FAIL mid_order: got %0d errors expected 0", orderErr); end
    assertCount++; if (lastErr !== 0) begin failCount++; $display("[TB] FAIL mid_last: got %0d errors expected 0", lastErr); end
    assertCount++; if (sCount !== CW'(1)) begin failCount++; $display("[TB] FAIL mid_count_post: got %0d expected 1", sCount); end
  endtask

  // Run every scenario in order, then report
  initial begin
    bus.enable  = 1'b1;
    bus.Empty   = 1'b1;
    bus.DataOut = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_three_words();
    test_burst32();
    test_backpressure();
    test_toggle();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
